// File: rtl/tgl_hs_pkg.sv
// Shared types and constants for the toggle handshake responder.
package tgl_hs_pkg;

  // Responder FSM: waiting for a request edge, or holding a word for the consumer.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Supported depth of the request synchronizer.
  localparam int SYNC_STAGES_MIN = 1;
  localparam int SYNC_STAGES_MAX = 3;

  // Keep the synchronizer depth inside the supported range.
  function automatic int clamp_sync_stages(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/toggle_hs_receiver_sync_chain.sv
// Parameterised flop chain used to synchronise toggle lines into clk.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the input through STAGES flops; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/toggle_hs_receiver.sv
// Responder end of the two-phase toggle handshake: detects request edges,
// captures the word, offers it on valid/ready and toggles ack on acceptance.
module toggle_hs_receiver
  import tgl_hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ack_tgl,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic              proto_err
);

  localparam int SYNC_DEPTH = clamp_sync_stages(SYNC_STAGES);

  logic req_s;

  sync_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_DEPTH)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (req_tgl),
    .q_o (req_s)
  );

  state_e              state_q, state_d;
  logic                req_prev_q, req_prev_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ack_q, ack_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                req_event;

  // A request is any level difference between the synchronised line and the
  // last level we serviced. req_prev only advances when a word is captured, so
  // a toggle arriving during HOLD stays pending until we are back in IDLE, and
  // a double toggle during HOLD cancels itself out.
  assign req_event = req_s ^ req_prev_q;

  // Next-state logic for FSM, data capture, ack, counter and error flag.
  always_comb begin
    state_d    = state_q;
    req_prev_d = req_prev_q;
    data_d     = data_q;
    ack_d      = ack_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (req_event) begin
          data_d     = data_in;
          req_prev_d = req_s;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (req_event) begin
          err_d = 1'b1;
        end
        if (out_ready) begin
          state_d = IDLE;
          ack_d   = ~ack_q;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_prev_q <= 1'b0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_prev_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign ack_tgl   = ack_q;
  assign evt_cnt   = cnt_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_toggle_hs_receiver.sv
// Scoreboard bench for toggle_hs_receiver: a default instance plus a
// CNT_W=4 instance share the same stimulus.
module tb_toggle_hs_receiver;

  logic       clk;
  logic       rst;
  logic       req_tgl;
  logic [7:0] data_in;
  logic       out_ready;

  logic       out_valid, ack_tgl, proto_err;
  logic [7:0] out_data;
  logic [15:0] evt_cnt;

  logic       s_out_valid, s_ack_tgl, s_proto_err;
  logic [7:0] s_out_data;
  logic [3:0] s_evt_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q[$];
  logic       exp_ack;
  int         exp_cnt;

  toggle_hs_receiver #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_tgl   (req_tgl),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ack_tgl   (ack_tgl),
    .evt_cnt   (evt_cnt),
    .proto_err (proto_err)
  );

  toggle_hs_receiver #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .req_tgl   (req_tgl),
    .data_in   (data_in),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .ack_tgl   (s_ack_tgl),
    .evt_cnt   (s_evt_cnt),
    .proto_err (s_proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Hold reset with random inputs, checking every output is cleared.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete();
    exp_ack = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      req_tgl   = 1'($urandom_range(0, 1));
      data_in   = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data",  {24'd0, out_data}, 32'd0);
      chk("rst_ack",   {31'd0, ack_tgl}, 32'd0);
      chk("rst_cnt",   {16'd0, evt_cnt}, 32'd0);
      chk("rst_err",   {31'd0, proto_err}, 32'd0);
    end
    rst       = 1'b0;
    req_tgl   = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {31'd0, out_valid}, 32'd0);
    $display("reset released");
  endtask

  // Initiator side: present a word and toggle the request line.
  task automatic send(input logic [7:0] word);
    data_in = word;
    req_tgl = ~req_tgl;
    exp_q.push_back(word);
  endtask

  // Advance until out_valid is seen, returning how many low cycles elapsed.
  task automatic wait_valid(input int limit, output int waited);
    waited = 0;
    while (!out_valid && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) chk("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  // Called at a negedge with out_valid high: accept the word at the next edge.
  task automatic do_accept();
    logic [7:0] w;
    chk("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk("out_data", {24'd0, out_data}, {24'd0, w});
    out_ready = 1'b1;
    @(negedge clk);
    exp_ack = ~exp_ack;
    exp_cnt++;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("ack",        {31'd0, ack_tgl}, {31'd0, exp_ack});
    chk("cnt",        {16'd0, evt_cnt}, 32'(exp_cnt));
    chk("sat_ack",    {31'd0, s_ack_tgl}, {31'd0, exp_ack});
    chk("sat_cnt",    {28'd0, s_evt_cnt}, (exp_cnt > 15) ? 32'd15 : 32'(exp_cnt));
    $display("xfer word=0x%02h ack=%0d cnt=%0d sat_cnt=%0d", w, ack_tgl, evt_cnt, s_evt_cnt);
  endtask

  initial begin
    int waited;
    rst = 1'b1; req_tgl = 1'b0; data_in = 8'h00; out_ready = 1'b0;
    exp_ack = 1'b0; exp_cnt = 0;

    // Reset
    do_reset(3);

    // Single transfer with exact latency
    out_ready = 1'b1;
    send(8'hA5);
    @(negedge clk); chk("lat_e0", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("lat_e1", {31'd0, out_valid}, 32'd0);
    @(negedge clk); chk("lat_e2", {31'd0, out_valid}, 32'd1);
    do_accept();

    // Backpressure
    out_ready = 1'b0;
    send(8'h3C);
    wait_valid(10, waited);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data",  {24'd0, out_data}, 32'h3C);
      chk("bp_ack",   {31'd0, ack_tgl}, {31'd0, exp_ack});
      @(negedge clk);
    end
    do_accept();
    @(negedge clk);
    chk("bp_single_ack", {31'd0, ack_tgl}, {31'd0, exp_ack});
    chk("bp_single_cnt", {16'd0, evt_cnt}, 32'(exp_cnt));

    // Protocol violation: second toggle while holding
    out_ready = 1'b0;
    send(8'h55);
    wait_valid(10, waited);
    chk("err_before", {31'd0, proto_err}, 32'd0);
    send(8'h11);
    repeat (4) @(negedge clk);
    chk("err_set", {31'd0, proto_err}, 32'd1);
    chk("err_hold_data", {24'd0, out_data}, 32'h55);
    do_accept();
    out_ready = 1'b0;
    wait_valid(10, waited);
    do_accept();
    chk("err_sticky", {31'd0, proto_err}, 32'd1);
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("err_no_extra", {31'd0, out_valid}, 32'd0);

    // Saturation: 20 back-to-back transfers, out_ready held high
    do_reset(2);
    chk("err_cleared", {31'd0, proto_err}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h20 + i));
      wait_valid(10, waited);
      chk("gap", (waited >= 1) ? 32'd1 : 32'd0, 32'd1);
      do_accept();
    end
    repeat (3) @(negedge clk);
    chk("sat_stays", {28'd0, s_evt_cnt}, 32'd15);
    chk("cnt_20",    {16'd0, evt_cnt}, 32'd20);

    // Reset in the middle of HOLD
    out_ready = 1'b0;
    send(8'h99);
    wait_valid(10, waited);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    req_tgl = 1'b0;
    exp_q.delete();
    exp_ack = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ack",   {31'd0, ack_tgl}, 32'd0);
    chk("mid_rst_cnt",   {16'd0, evt_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    send(8'h7E);
    wait_valid(10, waited);
    do_accept();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
